vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 640x480 VGA raster timing from the 100 MHz system clock and drives the monitor pins. It supplies `hCount`, `vCount` and `bright` to the block controller. It registers the controller's colour back out, aligned with the sync pulses. It also emits a once-per-frame tick that the game logic uses as its slow update enable.

## Interface
- `PIX_DIV`, 4: system clocks per pixel (100 MHz → 25 MHz pixel rate).
- `H_TOTAL`, 800: pixels per line; `hCount` range is 0..H_TOTAL-1.
- `H_SYNC`, 96: hSync low width in pixels, starting at `hCount` = 0.
- `H_DISP_START`, 144: first visible column.
- `H_DISP_END`, 783: last visible column, inclusive.
- `V_TOTAL`, 525: lines per frame.
- `V_SYNC`, 2: vSync low width in lines, starting at `vCount` = 0.
- `V_DISP_START`, 35: first visible line.
- `V_DISP_END`, 514: last visible line, inclusive.
- Ports:
- `clk` in 1: system clock, 100 MHz. One clock; all state is on its rising edge.
- `rst` in 1: reset. Asynchronous, active-low.
- `rgb_in` in 12: colour from the block controller, combinational from current `hCount`/`vCount`.
- `hCount` out 10: current pixel column, registered.
- `vCount` out 10: current line, registered.
- `bright` out 1: current pixel is in the visible area. Decoded from `hCount`/`vCount`.
- `pix_en` out 1: one-`clk` pulse every `PIX_DIV` clocks.
- `frame_tick` out 1: one-`clk` pulse per frame.
- `hSync` out 1: horizontal sync to the monitor, active low, registered.
- `vSync` out 1: vertical sync to the monitor, active low, registered.
- `rgb` out 12: colour to the monitor, registered.

## Operation
- Pixel divider `div`, 2 bits, counts 0..PIX_DIV-1 and wraps.
  - `pix_en` = (`div` == PIX_DIV-1), decoded from the register.
- On `clk` edges where `pix_en` is high, the counters advance:
  - `hCount` increments.
  - At H_TOTAL-1, `hCount` wraps to 0 and `vCount` increments.
  - When `vCount` is V_TOTAL-1 at that wrap, `vCount` also wraps to 0.
- `bright` = (H_DISP_START ≤ `hCount` ≤ H_DISP_END) && (V_DISP_START ≤ `vCount` ≤ V_DISP_END).
- Raw sync signals:
  - `hs_raw` = !(`hCount` < H_SYNC).
  - `vs_raw` = !(`vCount` < V_SYNC).
- Output stage, registered on the `pix_en` edge:
  - `rgb` ← `bright` ? `rgb_in` : 12'h000.
  - `hSync` ← `hs_raw`.
  - `vSync` ← `vs_raw`.
  - Colour and sync therefore stay mutually aligned.
- `frame_tick` = `pix_en` && `hCount` == H_TOTAL-1 && `vCount` == V_TOTAL-1.
  - Exactly one `clk` cycle per frame, on the edge where both counters wrap.
- Counter arithmetic is unsigned 10-bit. No value outside the wrap ranges is ever reachable.

## Timing
- Reset asserted (`rst` = 0), immediately and asynchronously:
  - `div`, `hCount`, `vCount` = 0.
  - `rgb` = 0.
  - `hSync` = 1, `vSync` = 1.
  - Consequently `bright` = 0, `pix_en` = 0, `frame_tick` = 0.
- After reset release:
  - First `pix_en` is in the 4th `clk` cycle (`div` = 3).
  - `hCount` = 1 after the 4th rising edge.
  - Each `hCount` value is held for exactly PIX_DIV clocks.
- Latency:
  - `rgb`/`hSync`/`vSync` lag `hCount`/`vCount` by exactly one pixel (PIX_DIV clocks).
  - The block controller sees no lag; it reads the counters directly.
- Period lengths:
  - Line = 800×4 = 3200 clk.
  - Frame = 525×3200 = 1,680,000 clk.
  - hSync low for 384 clk per line.
  - vSync low for 6400 clk per frame.
- Reset mid-line or mid-frame:
  - All state returns to reset values in the same instant.
  - After release, the raster restarts at (0,0). No partial-frame `frame_tick` is issued.
- `rgb_in` is sampled only on `pix_en` edges. Changes between samples have no effect.
- Edge masking: `rgb_in` is forced to black at `hCount` 143 and 784, and at `vCount` 34 and 515, even if `rgb_in` is nonzero.

## Test plan
- Reset: hold `rst` = 0 for 10 clk with `rgb_in` = 12'hFFF.
  - Requires `hCount` = `vCount` = 0, `rgb` = 0, `hSync` = `vSync` = 1, `pix_en` = `frame_tick` = 0 throughout.
  - After release, the first `pix_en` is in cycle 4.
- Horizontal timing: run 2 lines.
  - `pix_en` occurs every 4 clk.
  - `hSync` is low for 384 clk, line period is 3200 clk.
  - `vCount` steps 0→1 on the edge where `hCount` 799→0.
- Frame timing: run 2 full frames.
  - Exactly one `frame_tick` per 1,680,000 clk, coincident with `hCount` 799→0 and `vCount` 524→0.
  - `vSync` is low for 6400 clk.
- Visible window: drive `rgb_in` = 12'hF00 constantly.
  - `bright` = 1 exactly for `hCount` 144..783 and `vCount` 35..514.
  - `rgb` = F00 one pixel later over that window, 000 everywhere else, including at `hCount` 143/784 and `vCount` 34/515.
- Alignment: drive `rgb_in` = {2'b0, `hCount`} truncated to 12 bits.
  - Check `rgb` equals the previous pixel's `hCount` value.
  - Check `hSync` falls on the same clk edge as `rgb` presents the value for `hCount` = 0.
- Async reset mid-frame: assert `rst` = 0 between clock edges at `hCount` 400, `vCount` 200.
  - Outputs go to reset values without waiting for a `clk` edge.
  - After release, the raster restarts at (0,0).
  - The next `frame_tick` arrives 1,680,000 clk later.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480 VGA raster timing: pixel-rate divider, line/frame counters, visible-area decode
// and a one-pixel-delayed output stage that keeps colour and sync pulses aligned.
module vga_timing_gen #(
  parameter int PIX_DIV      = 4,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC       = 96,
  parameter int H_DISP_START = 144,
  parameter int H_DISP_END   = 783,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC       = 2,
  parameter int V_DISP_START = 35,
  parameter int V_DISP_END   = 514
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pix_en,
  output logic        frame_tick,
  output logic        hSync,
  output logic        vSync,
  output logic [11:0] rgb
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0] H_VIS_LO = 10'(H_DISP_START);
  localparam logic [9:0] H_VIS_HI = 10'(H_DISP_END);
  localparam logic [9:0] V_VIS_LO = 10'(V_DISP_START);
  localparam logic [9:0] V_VIS_HI = 10'(V_DISP_END);

  logic [DIV_W-1:0] div_reg;
  logic [9:0]       h_reg;
  logic [9:0]       v_reg;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic             hsync_reg;
  logic             vsync_reg;
  logic [11:0]      rgb_reg;
  logic [11:0]      rgb_next;
  logic             hs_raw;
  logic             vs_raw;
  logic             h_vis;
  logic             v_vis;
  logic             h_wrap;
  logic             v_wrap;

  assign pix_en = (div_reg == DIV_LAST);
  assign h_wrap = (h_reg == H_LAST);
  assign v_wrap = (v_reg == V_LAST);

  always_comb begin
    h_next = h_reg;
    v_next = v_reg;
    if (pix_en) begin
      if (h_wrap) begin
        h_next = 10'd0;
        v_next = v_wrap ? 10'd0 : v_reg + 10'd1;
      end else begin
        h_next = h_reg + 10'd1;
      end
    end
  end

  assign h_vis  = (h_reg >= H_VIS_LO) && (h_reg <= H_VIS_HI);
  assign v_vis  = (v_reg >= V_VIS_LO) && (v_reg <= V_VIS_HI);
  assign bright = h_vis && v_vis;

  assign hs_raw = !(h_reg < H_SYNC_W);
  assign vs_raw = !(v_reg < V_SYNC_W);

  // Blank each colour channel outside the visible window so porches stay black.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign rgb_next[gi*4 +: 4] = bright ? rgb_in[gi*4 +: 4] : 4'h0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_reg <= '0;
    end else if (pix_en) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_reg <= 10'd0;
      v_reg <= 10'd0;
    end else begin
      h_reg <= h_next;
      v_reg <= v_next;
    end
  end

  // Output stage samples on the same edge the counters advance, giving a one-pixel lag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_reg   <= 12'h000;
      hsync_reg <= 1'b1;
      vsync_reg <= 1'b1;
    end else if (pix_en) begin
      rgb_reg   <= rgb_next;
      hsync_reg <= hs_raw;
      vsync_reg <= vs_raw;
    end
  end

  assign frame_tick = pix_en && h_wrap && v_wrap;

  assign hCount = h_reg;
  assign vCount = v_reg;
  assign hSync  = hsync_reg;
  assign vSync  = vsync_reg;
  assign rgb    = rgb_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line timing, reduced-raster instance
// for frame-level timing, visible window, alignment and mid-frame async reset.
module tb_vga_timing_gen;

  localparam int BH   = 20;
  localparam int BHS  = 3;
  localparam int BHDS = 5;
  localparam int BHDE = 16;
  localparam int BV   = 10;
  localparam int BVS  = 2;
  localparam int BVDS = 3;
  localparam int BVDE = 7;

  logic        clk;
  logic        rst;
  int          n_edges;
  int          errors;
  int          checks;
  bit          mode_b;

  logic [11:0] rgb_in_a;
  logic [9:0]  hCount_a, vCount_a;
  logic        bright_a, pix_en_a, frame_tick_a, hSync_a, vSync_a;
  logic [11:0] rgb_a;

  logic [11:0] rgb_in_b;
  logic [9:0]  hCount_b, vCount_b;
  logic        bright_b, pix_en_b, frame_tick_b, hSync_b, vSync_b;
  logic [11:0] rgb_b;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst), .rgb_in(rgb_in_a),
    .hCount(hCount_a), .vCount(vCount_a), .bright(bright_a), .pix_en(pix_en_a),
    .frame_tick(frame_tick_a), .hSync(hSync_a), .vSync(vSync_a), .rgb(rgb_a)
  );

  vga_timing_gen #(
    .PIX_DIV(4), .H_TOTAL(BH), .H_SYNC(BHS), .H_DISP_START(BHDS), .H_DISP_END(BHDE),
    .V_TOTAL(BV), .V_SYNC(BVS), .V_DISP_START(BVDS), .V_DISP_END(BVDE)
  ) dut_b (
    .clk(clk), .rst(rst), .rgb_in(rgb_in_b),
    .hCount(hCount_b), .vCount(vCount_b), .bright(bright_b), .pix_en(pix_en_b),
    .frame_tick(frame_tick_b), .hSync(hSync_b), .vSync(vSync_b), .rgb(rgb_b)
  );

  assign rgb_in_a = 12'hFFF;
  // Between pix_en edges the colour is garbage; only the sampled value may reach rgb.
  assign rgb_in_b = mode_b ? {2'b00, hCount_b} : (pix_en_b ? 12'hF00 : 12'h0AB);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) n_edges <= 0;
    else      n_edges <= n_edges + 1;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          n;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        br;
    logic        pe;
    logic        hs;
    logic        vs;
    logic        ft;
    logic [11:0] rgb;
  } vec_t;

  function automatic vec_t mk(int n, int h, int v, bit pe, bit hs, bit vs);
    vec_t r;
    r.n = n; r.h = 10'(h); r.v = 10'(v);
    r.br = 1'b0; r.pe = pe; r.hs = hs; r.vs = vs; r.ft = 1'b0; r.rgb = 12'h000;
    return r;
  endfunction

  function automatic bit in_win_b(int h, int v);
    return (h >= BHDS) && (h <= BHDE) && (v >= BVDS) && (v <= BVDE);
  endfunction

  // Expected outputs of the reduced instance after n edges since reset release.
  function automatic logic [36:0] exp_b(int n);
    int p, h, v, q, qh, qv;
    logic br, pe, ft, hs, vs;
    logic [11:0] c;
    p  = n / 4;
    h  = p % BH;
    v  = (p / BH) % BV;
    br = in_win_b(h, v);
    pe = (n % 4) == 3;
    ft = pe && (h == BH - 1) && (v == BV - 1);
    if (n < 4) begin
      hs = 1'b1; vs = 1'b1; c = 12'h000;
    end else begin
      q  = p - 1;
      qh = q % BH;
      qv = (q / BH) % BV;
      hs = (qh >= BHS);
      vs = (qv >= BVS);
      if (in_win_b(qh, qv)) c = (4 * p > 800) ? 12'(qh) : 12'hF00;
      else                  c = 12'h000;
    end
    return {10'(h), 10'(v), br, pe, ft, hs, vs, c};
  endfunction

  vec_t tbl[12];

  initial begin
    int idx;
    int hs_low_a, pe_cnt_a, ft_cnt_a, vs_low_b, ft_cnt_b, tick_at;
    errors = 0; checks = 0; mode_b = 1'b0;
    rst = 1'b0;

    tbl[0]  = mk(0,    0,   0, 0, 1, 1);
    tbl[1]  = mk(3,    0,   0, 1, 1, 1);
    tbl[2]  = mk(4,    1,   0, 0, 0, 0);
    tbl[3]  = mk(7,    1,   0, 1, 0, 0);
    tbl[4]  = mk(387,  96,  0, 1, 0, 0);
    tbl[5]  = mk(388,  97,  0, 0, 1, 0);
    tbl[6]  = mk(3199, 799, 0, 1, 1, 0);
    tbl[7]  = mk(3200, 0,   1, 0, 1, 0);
    tbl[8]  = mk(3204, 1,   1, 0, 0, 0);
    tbl[9]  = mk(6400, 0,   2, 0, 1, 0);
    tbl[10] = mk(6403, 0,   2, 1, 1, 0);
    tbl[11] = mk(6404, 1,   2, 0, 0, 1);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_state",
          {hCount_a, vCount_a, rgb_a, hSync_a, vSync_a, pix_en_a, frame_tick_a, bright_a,
           hCount_b, vCount_b, rgb_b, hSync_b, vSync_b, pix_en_b, frame_tick_b},
          {10'd0, 10'd0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
           10'd0, 10'd0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0});
    end
    rst = 1'b1;

    hs_low_a = 0; pe_cnt_a = 0; ft_cnt_a = 0; vs_low_b = 0; ft_cnt_b = 0;
    fork
      begin
        idx = 0;
        for (int k = 0; k <= 6404; k++) begin
          if (idx < 12 && tbl[idx].n == k) begin
            $display("vec %0d n=%0d h=%0d v=%0d pe=%0b hs=%0b vs=%0b", idx, k,
                     hCount_a, vCount_a, pix_en_a, hSync_a, vSync_a);
            chk("a_h",      hCount_a,     tbl[idx].h);
            chk("a_v",      vCount_a,     tbl[idx].v);
            chk("a_bright", bright_a,     tbl[idx].br);
            chk("a_pix_en", pix_en_a,     tbl[idx].pe);
            chk("a_hsync",  hSync_a,      tbl[idx].hs);
            chk("a_vsync",  vSync_a,      tbl[idx].vs);
            chk("a_ftick",  frame_tick_a, tbl[idx].ft);
            chk("a_rgb",    rgb_a,        tbl[idx].rgb);
            idx++;
          end
          if (k >= 3200 && k < 6400) begin
            if (!hSync_a) hs_low_a++;
            if (pix_en_a) pe_cnt_a++;
          end
          if (frame_tick_a) ft_cnt_a++;
          @(negedge clk);
        end
        $display("line1 hsync_low=%0d pix_en=%0d ticks=%0d", hs_low_a, pe_cnt_a, ft_cnt_a);
        chk("a_hsync_low_clks", hs_low_a, 384);
        chk("a_pix_en_per_line", pe_cnt_a, 800);
        chk("a_no_frame_tick", ft_cnt_a, 0);
      end
      begin
        for (int k = 0; k < 1600; k++) begin
          chk($sformatf("b_scan_n%0d", k),
              {hCount_b, vCount_b, bright_b, pix_en_b, frame_tick_b, hSync_b, vSync_b, rgb_b},
              exp_b(k));
          if (k < 800 && !vSync_b) vs_low_b++;
          if (frame_tick_b) ft_cnt_b++;
          if (k == 800) mode_b = 1'b1;
          @(negedge clk);
        end
        $display("b frames vsync_low=%0d ticks=%0d", vs_low_b, ft_cnt_b);
        chk("b_vsync_low_clks", vs_low_b, 160);
        chk("b_frame_ticks", ft_cnt_b, 2);
      end
    join

    for (int k = 0; k < 1000 && n_edges != 6843; k++) @(negedge clk);
    chk("pre_reset_n", n_edges, 6843);
    chk("pre_reset_a_h", hCount_a, 10'd110);
    chk("pre_reset_b_hv", {hCount_b, vCount_b}, {10'd10, 10'd5});
    chk("pre_reset_b_rgb", rgb_b, 12'h009);
    chk("pre_reset_b_pe", pix_en_b, 1'b1);
    #1 rst = 1'b0;
    #1;
    $display("async reset h_a=%0d v_a=%0d h_b=%0d v_b=%0d rgb_b=%0h", hCount_a, vCount_a,
             hCount_b, vCount_b, rgb_b);
    chk("async_reset_a", {hCount_a, vCount_a, hSync_a, vSync_a, pix_en_a},
        {10'd0, 10'd0, 1'b1, 1'b1, 1'b0});
    chk("async_reset_b", {hCount_b, vCount_b, rgb_b, bright_b, pix_en_b, frame_tick_b},
        {10'd0, 10'd0, 12'h000, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst = 1'b1;

    tick_at = -1;
    for (int k = 0; k < 1000; k++) begin
      if (n_edges == 4) chk("restart_h_n4", {hCount_a, hCount_b}, {10'd1, 10'd1});
      if (frame_tick_b) begin
        tick_at = n_edges;
        chk("restart_tick_a_hv", {hCount_a, vCount_a}, {10'd199, 10'd0});
        break;
      end
      @(negedge clk);
    end
    $display("restart frame_tick at n=%0d", tick_at);
    chk("restart_tick_n", tick_at, 799);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
